// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction bus, decode-side handshake, redirect and occupancy.
// master = fetch_queue side, slave = memory/decode/branch-unit side.
interface fetch_queue_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32,
  parameter int unsigned CW   = 3
);
  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            idata_ok;
  logic [ILEN-1:0] idata;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
  logic            out_misaligned;
  logic            out_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   count;

  modport master (
    output ireq_valid, ireq_addr, out_valid, out_pc, out_instr, out_misaligned, count,
    input  idata_ok, idata, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr, out_misaligned, count,
    output idata_ok, idata, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC owner, single-outstanding bus requester and
// DEPTH-entry instruction FIFO feeding decode, with redirect/discard and misalign halt.
module fetch_queue #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input logic       clk,
  input logic       reset,
  fetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {FETCH, WAIT, DISCARD, HALT} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            mis;
  } entry_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          mem_q [DEPTH];
  entry_t          enq_entry, head;
  logic            enq, deq, free, aligned, out_valid;
  logic [XLEN-1:0] pc_inc;

  assign free      = count_q < CW'(DEPTH);
  assign aligned   = pc_q[1:0] == 2'b00;
  assign pc_inc    = pc_q + XLEN'(4);
  assign out_valid = count_q != '0;
  assign head      = mem_q[rd_q];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    enq       = 1'b0;
    enq_entry = '{pc: pc_q, instr: '0, mis: 1'b0};
    deq       = out_valid && bus.out_ready && !bus.redirect_valid;

    unique case (state_q)
      FETCH: begin
        if (free) begin
          if (!aligned) begin
            enq           = 1'b1;
            enq_entry.mis = 1'b1;
            state_d       = HALT;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.idata_ok) begin
          enq             = 1'b1;
          enq_entry.instr = bus.idata;
          pc_d            = pc_inc;
          // Keep streaming only if a slot is still free after this cycle's enq/deq.
          if (((count_q + CW'(1) - CW'(deq)) < CW'(DEPTH)) && (pc_inc[1:0] == 2'b00))
            state_d = WAIT;
          else
            state_d = FETCH;
        end
      end
      DISCARD: begin
        if (bus.idata_ok) state_d = FETCH;
      end
      HALT: ;
      default: state_d = FETCH;
    endcase

    // The bus cannot abort, so an unanswered request keeps its old address in addr_q.
    if (bus.redirect_valid) begin
      enq  = 1'b0;
      pc_d = bus.redirect_pc;
      if (state_q == WAIT && !bus.idata_ok) begin
        state_d = DISCARD;
        addr_d  = pc_q;
      end else if (state_q == DISCARD && !bus.idata_ok) begin
        state_d = DISCARD;
      end else begin
        state_d = FETCH;
      end
    end

    if (bus.redirect_valid) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      count_d = count_q + CW'(enq) - CW'(deq);
      rd_d    = rd_q + AW'(deq);
      wr_d    = wr_q + AW'(enq);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_q] <= enq_entry;
  end

  assign bus.ireq_valid = reset &&
                          ((state_q == FETCH && free && aligned && !bus.redirect_valid) ||
                           state_q == WAIT || state_q == DISCARD);
  assign bus.ireq_addr      = (state_q == DISCARD) ? addr_q : pc_q;
  assign bus.out_valid      = out_valid;
  assign bus.out_pc         = out_valid ? head.pc    : '0;
  assign bus.out_instr      = out_valid ? head.instr : '0;
  assign bus.out_misaligned = out_valid && head.mis;
  assign bus.count          = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector bench for fetch_queue: each record gives one cycle's inputs and
// the outputs expected during that cycle (before the next rising edge).
module tb_fetch_queue;
  localparam logic [63:0] B = 64'h8000_0000;

  typedef struct {
    logic        rst;
    logic        ok;
    logic [31:0] dat;
    logic        rdy;
    logic        rv;
    logic [63:0] rpc;
    logic        eiv;
    logic [63:0] eaddr;
    logic        eov;
    logic [63:0] epc;
    logic [31:0] ei;
    logic        em;
    logic [2:0]  ec;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t tbl[$];

  fetch_queue_if #(.XLEN(64), .ILEN(32), .CW(3)) bus ();

  fetch_queue #(
    .XLEN    (64),
    .ILEN    (32),
    .DEPTH   (4),
    .RESET_PC(64'h8000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic ok, input logic [31:0] dat,
                              input logic rdy, input logic rv, input logic [63:0] rpc,
                              input logic eiv, input logic [63:0] eaddr, input logic eov,
                              input logic [63:0] epc, input logic [31:0] ei,
                              input logic em, input logic [2:0] ec);
    vec_t v;
    v.rst = rst; v.ok = ok; v.dat = dat; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.eiv = eiv; v.eaddr = eaddr; v.eov = eov; v.epc = epc; v.ei = ei; v.em = em; v.ec = ec;
    return v;
  endfunction

  task automatic apply(input string nm, input vec_t v);
    @(negedge clk);
    reset              = v.rst;
    bus.idata_ok       = v.ok;
    bus.idata          = v.dat;
    bus.out_ready      = v.rdy;
    bus.redirect_valid = v.rv;
    bus.redirect_pc    = v.rpc;
    #1;
    vectors++;
    if (bus.ireq_valid !== v.eiv || (v.eiv && bus.ireq_addr !== v.eaddr) ||
        bus.out_valid !== v.eov || bus.out_pc !== v.epc || bus.out_instr !== v.ei ||
        bus.out_misaligned !== v.em || bus.count !== v.ec) begin
      miscompares++;
      $display("FAIL %s: got iv=%0b addr=%h ov=%0b pc=%h instr=%h mis=%0b cnt=%0d, want iv=%0b addr=%h ov=%0b pc=%h instr=%h mis=%0b cnt=%0d",
               nm, bus.ireq_valid, bus.ireq_addr, bus.out_valid, bus.out_pc, bus.out_instr,
               bus.out_misaligned, bus.count, v.eiv, v.eaddr, v.eov, v.epc, v.ei, v.em, v.ec);
    end
  endtask

  initial begin
    reset              = 1'b0;
    bus.idata_ok       = 1'b0;
    bus.idata          = '0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(posedge clk);

    // Streaming at one per cycle, then backpressure until the FIFO fills.
    tbl.push_back(mk(0,0,32'h0,0,0,0, 0,0,   0,0,0,0,0));
    tbl.push_back(mk(1,1,32'h13,1,0,0, 1,B,     0,0,0,0,0));
    tbl.push_back(mk(1,1,32'h13,1,0,0, 1,B,     0,0,0,0,0));
    tbl.push_back(mk(1,1,32'h13,1,0,0, 1,B+4,   1,B,32'h13,0,1));
    tbl.push_back(mk(1,1,32'h13,1,0,0, 1,B+8,   1,B+4,32'h13,0,1));
    tbl.push_back(mk(1,1,32'h13,1,0,0, 1,B+'hC, 1,B+8,32'h13,0,1));
    tbl.push_back(mk(0,0,32'h0,0,0,0,  0,0,     1,B+'hC,32'h13,0,1));
    tbl.push_back(mk(0,0,32'h0,0,0,0,  0,0,     0,0,0,0,0));
    tbl.push_back(mk(1,1,32'hAAAA0000,0,0,0, 1,B, 0,0,0,0,0));
    tbl.push_back(mk(1,1,32'h11,0,0,0, 1,B,      0,0,0,0,0));
    tbl.push_back(mk(1,1,32'h22,0,0,0, 1,B+4,    1,B,32'h11,0,1));
    tbl.push_back(mk(1,1,32'h33,0,0,0, 1,B+8,    1,B,32'h11,0,2));
    tbl.push_back(mk(1,1,32'h44,0,0,0, 1,B+'hC,  1,B,32'h11,0,3));
    tbl.push_back(mk(1,1,32'h99,0,0,0, 0,0,      1,B,32'h11,0,4));
    tbl.push_back(mk(1,0,32'h0,1,0,0,  0,0,      1,B,32'h11,0,4));
    tbl.push_back(mk(1,0,32'h0,0,0,0,  1,B+'h10, 1,B+4,32'h22,0,3));
    tbl.push_back(mk(1,1,32'h55,0,0,0, 1,B+'h10, 1,B+4,32'h22,0,3));
    tbl.push_back(mk(1,0,32'h0,1,0,0,  0,0,      1,B+4,32'h22,0,4));
    tbl.push_back(mk(1,0,32'h0,1,0,0,  1,B+'h14, 1,B+8,32'h33,0,3));
    tbl.push_back(mk(1,0,32'h0,1,0,0,  1,B+'h14, 1,B+'hC,32'h44,0,2));
    tbl.push_back(mk(1,0,32'h0,1,0,0,  1,B+'h14, 1,B+'h10,32'h55,0,1));
    tbl.push_back(mk(1,0,32'h0,1,0,0,  1,B+'h14, 0,0,0,0,0));
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // Redirect while a request is outstanding: old address held, response dropped.
    apply("rst_a",   mk(0,0,0,0,0,0, 0,0, 0,0,0,0,0));
    apply("rst_b",   mk(0,0,0,0,0,0, 0,0, 0,0,0,0,0));
    apply("redir_0", mk(1,0,32'h0,1,0,0, 1,B,   0,0,0,0,0));
    apply("redir_1", mk(1,1,32'h13,1,0,0, 1,B,   0,0,0,0,0));
    apply("redir_2", mk(1,1,32'h13,1,0,0, 1,B+4, 1,B,32'h13,0,1));
    apply("redir_3", mk(1,0,32'h0,0,0,0,  1,B+8, 1,B+4,32'h13,0,1));
    apply("redir_4", mk(1,0,32'h0,0,1,B+'h1000, 1,B+8, 1,B+4,32'h13,0,1));
    apply("discard_hold", mk(1,0,32'h0,0,0,0, 1,B+8, 0,0,0,0,0));
    apply("discard_resp", mk(1,1,32'hDEAD,0,0,0, 1,B+8, 0,0,0,0,0));
    apply("redir_target", mk(1,0,32'h0,0,0,0, 1,B+'h1000, 0,0,0,0,0));
    apply("no_dead",      mk(1,0,32'h0,0,0,0, 1,B+'h1000, 0,0,0,0,0));

    // Redirect in the same cycle as the response.
    apply("same_0", mk(1,1,32'hBEEF,1,1,B+'h2000, 1,B+'h1000, 0,0,0,0,0));
    apply("same_1", mk(1,0,32'h0,1,0,0, 1,B+'h2000, 0,0,0,0,0));
    apply("same_2", mk(1,1,32'h77,1,0,0, 1,B+'h2000, 0,0,0,0,0));
    apply("same_3", mk(1,0,32'h0,0,0,0, 1,B+'h2004, 1,B+'h2000,32'h77,0,1));

    // Misaligned redirect target: exception entry, halt until the next redirect.
    apply("mis_0", mk(1,1,32'h5555,0,1,B+'h102, 1,B+'h2004, 1,B+'h2000,32'h77,0,1));
    apply("mis_1", mk(1,0,32'h0,0,0,0, 0,0, 0,0,0,0,0));
    apply("mis_2", mk(1,0,32'h0,0,0,0, 0,0, 1,B+'h102,32'h0,1,1));
    apply("mis_3", mk(1,0,32'h0,1,0,0, 0,0, 1,B+'h102,32'h0,1,1));
    apply("mis_4", mk(1,0,32'h0,0,0,0, 0,0, 0,0,0,0,0));
    apply("mis_5", mk(1,0,32'h0,0,1,B+'h200, 0,0, 0,0,0,0,0));
    apply("mis_6", mk(1,0,32'h0,0,0,0, 1,B+'h200, 0,0,0,0,0));

    // Reset while a request is outstanding with two entries queued.
    apply("rwait_0", mk(1,1,32'h61,0,0,0, 1,B+'h200, 0,0,0,0,0));
    apply("rwait_1", mk(1,1,32'h62,0,0,0, 1,B+'h204, 1,B+'h200,32'h61,0,1));
    apply("rwait_2", mk(1,0,32'h0,0,0,0,  1,B+'h208, 1,B+'h200,32'h61,0,2));
    apply("rwait_3", mk(0,0,32'h0,0,0,0,  0,0,       1,B+'h200,32'h61,0,2));
    apply("rwait_4", mk(0,0,32'h0,0,0,0,  0,0,       0,0,0,0,0));
    apply("rwait_5", mk(1,0,32'h0,0,0,0,  1,B,       0,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
